uart_slot_arbiter: RTL and testbench

UART_SLOT_ARBITER -- requirements
Module: uart_slot_arbiter

---
 rtl/uart_slot_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_slot_arbiter.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_slot_arbiter.sv
// Shares one UART register slot between two TX requesters and one RX consumer.
// Defining UART_ARB_DVSR_WR_EN adds a cfg_* port trio for runtime baud-divisor updates.
module uart_slot_arbiter #(
    parameter logic [10:0] DVSR_INIT = 11'd53
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        cs,
    output logic        read,
    output logic        write,
    output logic [4:0]  addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
`ifdef UART_ARB_DVSR_WR_EN
    input  logic        cfg_valid,
    input  logic [10:0] cfg_dvsr,
    output logic        cfg_ready,
`endif
    output logic [2:0]  dbg_state
);
    // Handshakes: a transfer completes on a rising edge where valid and ready are both
    // high; the producer holds data stable while valid until it sees ready.
    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_IDLE = 3'd3;
    localparam logic [2:0] S_TX   = 3'd4;
    localparam logic [2:0] S_RX   = 3'd5;
`ifdef UART_ARB_DVSR_WR_EN
    localparam logic [2:0] S_CFG  = 3'd6;
`endif

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       r_last_grant;
    logic [7:0] r_tx_byte;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       w_idle;
    logic       w_cfg_go;
    logic       w_rx_go;
    logic       w_tx_go;
    logic       w_grant1;
    logic       w_unused;

    assign w_idle   = (r_state == S_IDLE);
    assign w_rx_go  = w_idle && !w_cfg_go && !rd_data[8] && !r_rx_valid;
    assign w_tx_go  = w_idle && !w_cfg_go && !w_rx_go && !rd_data[9] && (req0_valid || req1_valid);
    // Requester 1 wins when it is alone or when requester 0 was granted last.
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_tx_go && !w_grant1;
    assign req1_ready = w_tx_go && w_grant1;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign dbg_state  = r_state;
    assign w_unused   = ^rd_data[31:10];

`ifdef UART_ARB_DVSR_WR_EN
    logic [10:0] r_cfg_dvsr;
    assign w_cfg_go  = w_idle && cfg_valid;
    assign cfg_ready = w_cfg_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_dvsr <= 11'd0;
        end else if (w_cfg_go) begin
            r_cfg_dvsr <= cfg_dvsr;
        end
    end
`else
    assign w_cfg_go = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT: w_next_state = S_INIT;
            S_INIT: w_next_state = S_GAP;
            S_TX:   w_next_state = S_GAP;
            S_RX:   w_next_state = S_GAP;
`ifdef UART_ARB_DVSR_WR_EN
            S_CFG:  w_next_state = S_GAP;
`endif
            S_GAP:  w_next_state = S_IDLE;
            S_IDLE: begin
`ifdef UART_ARB_DVSR_WR_EN
                if (w_cfg_go) w_next_state = S_CFG;
                else
`endif
                if (w_rx_go) w_next_state = S_RX;
                else if (w_tx_go) w_next_state = S_TX;
            end
            default: w_next_state = S_BOOT;
        endcase
    end

    // Slot strobes are a pure decode of the current state.
    always_comb begin
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'd0;
        case (r_state)
            S_INIT: begin
                cs      = 1'b1;
                write   = 1'b1;
                addr    = 5'd1;
                wr_data = {21'b0, DVSR_INIT};
            end
            S_IDLE: begin
                cs   = 1'b1;
                read = 1'b1;
            end
            S_TX: begin
                cs      = 1'b1;
                write   = 1'b1;
                addr    = 5'd2;
                wr_data = {24'b0, r_tx_byte};
            end
            S_RX: begin
                cs    = 1'b1;
                write = 1'b1;
                addr  = 5'd3;
            end
`ifdef UART_ARB_DVSR_WR_EN
            S_CFG: begin
                cs      = 1'b1;
                write   = 1'b1;
                addr    = 5'd1;
                wr_data = {21'b0, r_cfg_dvsr};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_BOOT;
            r_last_grant <= 1'b1;
            r_tx_byte    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_tx_go) begin
                r_last_grant <= w_grant1;
                r_tx_byte    <= w_grant1 ? req1_data : req0_data;
            end
            // A drain in the same IDLE cycle keeps the buffer busy, so capture waits a visit.
            if (w_rx_go) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= rd_data[7:0];
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_slot_arbiter.sv
// Self-checking bench for uart_slot_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the UART FIFOs, requesters and consumer.
module tb_uart_slot_arbiter;
    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [2:0]  dbg_state;
`ifdef UART_ARB_DVSR_WR_EN
    logic        cfg_valid;
    logic [10:0] cfg_dvsr;
    logic        cfg_ready;
`endif

    int n_cmp = 0;
    int n_err = 0;

    uart_slot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .cs         (cs),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
`ifdef UART_ARB_DVSR_WR_EN
        .cfg_valid  (cfg_valid),
        .cfg_dvsr   (cfg_dvsr),
        .cfg_ready  (cfg_ready),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Driver tasks: inputs change only just after a falling edge, outputs are sampled #1 later.
    task automatic idle_inputs();
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        rx_ready   = 1'b0;
        rd_data    = 32'h0000_0100;
`ifdef UART_ARB_DVSR_WR_EN
        cfg_valid  = 1'b0;
        cfg_dvsr   = 11'd0;
`endif
    endtask

    // Leaves the bench in the BOOT cycle: next falling edges see INIT, GAP, then IDLE.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({cs, read, write, addr, wr_data, req0_ready, req1_ready, rx_valid, rx_data} !== 51'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got cs=%b rd=%b wr=%b addr=%0d wd=%h rdy=%b%b rxv=%b rxd=%h expected all zero",
                     cs, read, write, addr, wr_data, req0_ready, req1_ready, rx_valid, rx_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({cs, read, write} !== 3'b000) begin
            n_err++;
            $display("FAIL boot_cycle: got cs/rd/wr=%b expected 000", {cs, read, write});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({cs, read, write, addr, wr_data} !== {1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0035}) begin
            n_err++;
            $display("FAIL init_write: got cs/rd/wr=%b addr=%0d data=%h expected 101 addr=1 data=00000035",
                     {cs, read, write}, addr, wr_data);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({cs, read, write} !== 3'b000) begin
            n_err++;
            $display("FAIL gap_after_init: got cs/rd/wr=%b expected 000", {cs, read, write});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({cs, read, write, addr} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL idle_read: got cs/rd/wr=%b addr=%0d expected 110 addr=0", {cs, read, write}, addr);
        end
    endtask

    task automatic test_fairness();
        int nw;
        int last_c;
        logic [7:0] exp_b;
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'hA0;
        req1_valid = 1'b1;
        req1_data  = 8'hB1;
        nw = 0;
        last_c = 0;
        for (int c = 0; c < 40 && nw < 6; c++) begin
            @(negedge clk);
            #1;
            if (write && addr == 5'd2) begin
                exp_b = (nw % 2 == 0) ? 8'hA0 : 8'hB1;
                n_cmp++;
                if (wr_data !== {24'b0, exp_b}) begin
                    n_err++;
                    $display("FAIL fair_data[%0d]: got %h expected %h", nw, wr_data, {24'b0, exp_b});
                end
                if (nw > 0) begin
                    n_cmp++;
                    if (c - last_c != 3) begin
                        n_err++;
                        $display("FAIL fair_spacing[%0d]: got %0d cycles expected 3", nw, c - last_c);
                    end
                end
                last_c = c;
                nw++;
            end
        end
        n_cmp++;
        if (nw != 6) begin
            n_err++;
            $display("FAIL fair_count: got %0d writes expected 6", nw);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int n_rdy;
        int n_wr;
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h3C;
        rd_data    = 32'h0000_0300;
        n_rdy = 0;
        n_wr  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (req0_ready || req1_ready) n_rdy++;
            if (write && addr == 5'd2) n_wr++;
        end
        n_cmp++;
        if (n_rdy != 0 || n_wr != 0) begin
            n_err++;
            $display("FAIL bp_stall: got %0d readies %0d tx writes expected 0 and 0", n_rdy, n_wr);
        end
        @(negedge clk);
        rd_data = 32'h0000_0100;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_release_grant: got ready=%b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({write, addr, wr_data} !== {1'b1, 5'd2, 32'h0000_003C}) begin
            n_err++;
            $display("FAIL bp_tx_write: got wr=%b addr=%0d data=%h expected 1 addr=2 data=0000003c",
                     write, addr, wr_data);
        end
        idle_inputs();
    endtask

    task automatic test_rx();
        int pops;
        do_reset();
        rd_data = 32'h0000_0055;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (write && addr == 5'd3) pops++;
        end
        n_cmp++;
        if (pops != 1) begin
            n_err++;
            $display("FAIL rx_single_pop: got %0d pops expected 1", pops);
        end
        n_cmp++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL rx_held: got valid=%b data=%h expected 1 55", rx_valid, rx_data);
        end
        @(negedge clk);
        rx_ready = 1'b1;
        rd_data  = 32'h0000_0077;
        #1;
        n_cmp++;
        if ({rx_valid, read, write} !== 3'b110) begin
            n_err++;
            $display("FAIL rx_drain_cycle: got valid/rd/wr=%b expected 110", {rx_valid, read, write});
        end
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        n_cmp++;
        if ({rx_valid, read, write} !== 3'b010) begin
            n_err++;
            $display("FAIL rx_no_same_cycle_capture: got valid/rd/wr=%b expected 010", {rx_valid, read, write});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({write, addr, rx_valid, rx_data} !== {1'b1, 5'd3, 1'b1, 8'h77}) begin
            n_err++;
            $display("FAIL rx_second_capture: got wr=%b addr=%0d valid=%b data=%h expected 1 3 1 77",
                     write, addr, rx_valid, rx_data);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        int nops;
        int op_c[2];
        logic [4:0] op_a[2];
        logic [31:0] op_d[2];
        logic clr_rx;
        logic drop0;
        do_reset();
        rd_data    = 32'h0000_0042;
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        rx_ready   = 1'b1;
        nops = 0;
        clr_rx = 1'b0;
        drop0 = 1'b0;
        for (int c = 0; c < 30 && nops < 2; c++) begin
            @(negedge clk);
            if (clr_rx) rd_data = 32'h0000_0100;
            if (drop0) req0_valid = 1'b0;
            #1;
            if (req0_ready) drop0 = 1'b1;
            if (write && addr != 5'd1) begin
                op_c[nops] = c;
                op_a[nops] = addr;
                op_d[nops] = wr_data;
                if (addr == 5'd3) clr_rx = 1'b1;
                nops++;
            end
        end
        n_cmp++;
        if (nops != 2) begin
            n_err++;
            $display("FAIL prio_ops: got %0d ops expected 2", nops);
        end else begin
            n_cmp++;
            if (op_a[0] !== 5'd3 || op_a[1] !== 5'd2 || op_d[1] !== 32'h0000_005A) begin
                n_err++;
                $display("FAIL prio_order: got addr %0d then %0d data %h expected 3 then 2 data 0000005a",
                         op_a[0], op_a[1], op_d[1]);
            end
            n_cmp++;
            if (op_c[1] - op_c[0] != 3) begin
                n_err++;
                $display("FAIL prio_spacing: got %0d cycles expected 3", op_c[1] - op_c[0]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_tx();
        logic found;
        int n_bad;
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h99;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (write && addr == 5'd2) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL midtx_reach_tx: got no tx write expected one within 20 cycles");
        end
        reset = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({cs, write} !== 2'b00) begin
            n_err++;
            $display("FAIL midtx_abort: got cs/wr=%b expected 00", {cs, write});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({write, addr, wr_data} !== {1'b1, 5'd1, 32'h0000_0035}) begin
            n_err++;
            $display("FAIL midtx_reboot_init: got wr=%b addr=%0d data=%h expected 1 addr=1 data=00000035",
                     write, addr, wr_data);
        end
        n_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (write && addr == 5'd2) n_bad++;
        end
        n_cmp++;
        if (n_bad != 0) begin
            n_err++;
            $display("FAIL midtx_discard: got %0d tx writes expected 0", n_bad);
        end
    endtask

`ifdef UART_ARB_DVSR_WR_EN
    task automatic test_cfg();
        do_reset();
        repeat (2) @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_dvsr  = 11'h1B;
        #1;
        n_cmp++;
        if ({cfg_ready, read} !== 2'b11) begin
            n_err++;
            $display("FAIL cfg_ready: got cfg_ready/rd=%b expected 11", {cfg_ready, read});
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        n_cmp++;
        if ({write, addr, wr_data} !== {1'b1, 5'd1, 32'h0000_001B}) begin
            n_err++;
            $display("FAIL cfg_write: got wr=%b addr=%0d data=%h expected 1 addr=1 data=0000001b",
                     write, addr, wr_data);
        end
        idle_inputs();
    endtask
`endif

    // Randomized run: the bench plays the UART (RX FIFO queue, random tx_full), two
    // requesters and a consumer; the model predicts every slot operation and delivery.
    task automatic test_random();
        logic [7:0]  uart_q[$];
        logic [7:0]  exp_q[$];
        logic        last_grant;
        int          phase;
        logic [4:0]  pend_addr;
        logic [31:0] pend_data;
        logic        push_en;
        logic [7:0]  push_b;
        logic        want_rx;
        logic        want_tx;
        logic        g1;
        logic        drop0;
        logic        drop1;
        do_reset();
        repeat (2) @(negedge clk);
        last_grant = 1'b1;
        phase = 0;
        pend_addr = 5'd0;
        pend_data = 32'd0;
        drop0 = 1'b0;
        drop1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
            drop0 = 1'b0;
            drop1 = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_data  = 8'($urandom_range(0, 255));
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_data  = 8'($urandom_range(0, 255));
            end
            if (uart_q.size() < 4 && $urandom_range(0, 3) == 0)
                uart_q.push_back(8'($urandom_range(0, 255)));
            rd_data = {22'b0, ($urandom_range(0, 3) == 0), (uart_q.size() == 0),
                       (uart_q.size() != 0) ? uart_q[0] : 8'h00};
            rx_ready = ($urandom_range(0, 1) == 1);
            #1;
            push_en = 1'b0;
            push_b  = 8'h00;
            n_cmp++;
            if (rx_valid !== (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL rnd_rx_valid c=%0d: got %b expected %b", c, rx_valid, exp_q.size() != 0);
            end
            if (rx_valid && exp_q.size() != 0) begin
                n_cmp++;
                if (rx_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rnd_rx_data c=%0d: got %h expected %h", c, rx_data, exp_q[0]);
                end
            end
            if (phase == 0) begin
                n_cmp++;
                if ({cs, read, write, addr} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
                    n_err++;
                    $display("FAIL rnd_idle c=%0d: got cs/rd/wr=%b addr=%0d expected 110 addr=0",
                             c, {cs, read, write}, addr);
                end
                want_rx = !rd_data[8] && exp_q.size() == 0;
                want_tx = !want_rx && !rd_data[9] && (req0_valid || req1_valid);
                g1 = req1_valid && (!req0_valid || !last_grant);
                n_cmp++;
                if ({req0_ready, req1_ready} !== {want_tx && !g1, want_tx && g1}) begin
                    n_err++;
                    $display("FAIL rnd_grant c=%0d: got ready=%b expected %b",
                             c, {req0_ready, req1_ready}, {want_tx && !g1, want_tx && g1});
                end
                if (want_rx) begin
                    pend_addr = 5'd3;
                    pend_data = 32'd0;
                    push_en = 1'b1;
                    push_b = rd_data[7:0];
                    phase = 1;
                end else if (want_tx) begin
                    pend_addr = 5'd2;
                    pend_data = {24'b0, g1 ? req1_data : req0_data};
                    last_grant = g1;
                    drop0 = !g1;
                    drop1 = g1;
                    phase = 1;
                end
            end else if (phase == 1) begin
                n_cmp++;
                if ({cs, read, write, addr, wr_data, req0_ready, req1_ready} !==
                    {1'b1, 1'b0, 1'b1, pend_addr, pend_data, 2'b00}) begin
                    n_err++;
                    $display("FAIL rnd_op c=%0d: got cs/rd/wr=%b addr=%0d data=%h expected 101 addr=%0d data=%h",
                             c, {cs, read, write}, addr, wr_data, pend_addr, pend_data);
                end
                if (pend_addr == 5'd3 && uart_q.size() != 0) void'(uart_q.pop_front());
                phase = 2;
            end else begin
                n_cmp++;
                if ({cs, read, write, req0_ready, req1_ready} !== 5'b00000) begin
                    n_err++;
                    $display("FAIL rnd_gap c=%0d: got cs/rd/wr/rdy=%b expected 00000",
                             c, {cs, read, write, req0_ready, req1_ready});
                end
                phase = 0;
            end
            if (rx_valid && rx_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (push_en) exp_q.push_back(push_b);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fairness();
        test_backpressure();
        test_rx();
        test_priority();
        test_reset_mid_tx();
`ifdef UART_ARB_DVSR_WR_EN
        test_cfg();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
